// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for a 1x8 serial demux: arbitrates among eight requesters
// and delivers up to BURST bits to the granted channel through registered outputs.
module demux_rr_sched #(
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] out_data,
  output logic [7:0] out_valid
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SERVE = 1'b1;

  logic [0:0]       r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_grant;

  logic [2:0] w_pick;
  logic       w_any;
  logic       w_xfer;
  logic       w_last;
  logic       w_drop;

  // First requester at or after the pointer, wrapping modulo 8.
  always_comb begin
    w_pick = r_ptr;
    w_any  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!w_any && req[r_ptr + 3'(i)]) begin
        w_pick = r_ptr + 3'(i);
        w_any  = 1'b1;
      end
    end
  end

  assign en       = (r_state == S_SERVE);
  assign in_ready = en && req[r_sel];
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = w_xfer && (r_cnt == CNT_W'(BURST - 1));
  assign w_drop   = en && !req[r_sel];
  assign grant    = r_grant;
  assign sel      = r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_sel   <= 3'd0;
      r_cnt   <= '0;
      r_grant <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_grant <= 8'b1 << w_pick;
            r_cnt   <= '0;
            r_state <= S_SERVE;
          end
        end
        default: begin
          // A dropped request or the final beat both release the channel.
          if (w_drop || w_last) begin
            r_state <= S_IDLE;
            r_ptr   <= r_sel + 3'd1;
            r_grant <= 8'd0;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      logic r_od;
      logic r_ov;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_od <= 1'b0;
          r_ov <= 1'b0;
        end else begin
          r_ov <= w_xfer && (r_sel == 3'(gi));
          if (w_xfer && (r_sel == 3'(gi))) begin
            r_od <= in_data;
          end
        end
      end
      assign out_data[gi]  = r_od;
      assign out_valid[gi] = r_ov;
    end
  endgenerate

endmodule
